ht_cmd_ingress: RTL and testbench

// Receiving end of the hash-table command channel (valid/ready, key/value/opcode).

---
 rtl/ht_cmd_ingress.sv | 129 ++++++++++++
 tb/tb_ht_cmd_ingress.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_cmd_ingress.sv
// Command ingress for the hash-table pipeline: buffers commands in a FIFO and
// issues them in order, tagged, holding back any key that is still in flight.
module ht_cmd_ingress #(
    parameter int KEY_WIDTH    = 32,
    parameter int VALUE_WIDTH  = 16,
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 4,
    localparam int TAG_W  = $clog2(MAX_INFLIGHT),
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int ICNT_W = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [KEY_WIDTH-1:0]   cmd_key_i,
    input  logic [VALUE_WIDTH-1:0] cmd_value_i,
    input  logic [1:0]             cmd_opcode_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [KEY_WIDTH-1:0]   out_key_o,
    output logic [VALUE_WIDTH-1:0] out_value_o,
    output logic [1:0]             out_opcode_o,
    output logic [TAG_W-1:0]       out_tag_o,
    input  logic                   res_valid_i,
    input  logic                   res_ready_i,
    input  logic [TAG_W-1:0]       res_tag_i,
    output logic [CNT_W-1:0]       fifo_cnt_o,
    output logic [ICNT_W-1:0]      inflight_cnt_o,
    output logic                   err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(DEPTH);
    localparam logic [ICNT_W-1:0] SLOTS_ALL = ICNT_W'(MAX_INFLIGHT);
    localparam logic [1:0]        OP_RSVD   = 2'd3;

    logic [KEY_WIDTH-1:0]   key_mem [DEPTH];
    logic [VALUE_WIDTH-1:0] val_mem [DEPTH];
    logic [1:0]             op_mem  [DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;

    logic [MAX_INFLIGHT-1:0] busy;
    logic [KEY_WIDTH-1:0]    slot_key [MAX_INFLIGHT];
    logic [ICNT_W-1:0]       inflight_cnt;
    logic                    err;
    logic                    hold;
    logic [TAG_W-1:0]        hold_tag;

    logic             accept, push, pop, retire, retire_ok, hazard, empty;
    logic [TAG_W-1:0] free_tag;

    assign cmd_ready_o = rst_n_i && (fifo_cnt != FIFO_FULL);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign push        = accept && (cmd_opcode_i != OP_RSVD);
    assign empty       = (fifo_cnt == '0);

    assign out_key_o    = key_mem[rd_ptr];
    assign out_value_o  = val_mem[rd_ptr];
    assign out_opcode_o = op_mem[rd_ptr];

    // Descending scan so the lowest idle slot is the last one to win.
    always_comb begin
        hazard   = 1'b0;
        free_tag = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (busy[i] && (slot_key[i] == out_key_o)) hazard = 1'b1;
            if (!busy[i]) free_tag = TAG_W'(i);
        end
    end

    assign out_valid_o = rst_n_i && !empty && !hazard && (inflight_cnt < SLOTS_ALL);
    // A stalled offer keeps its tag even if a lower slot retires meanwhile.
    assign out_tag_o   = hold ? hold_tag : free_tag;
    assign pop         = out_valid_o && out_ready_i;
    assign retire      = res_valid_i && res_ready_i;
    assign retire_ok   = retire && busy[res_tag_i];

    assign fifo_cnt_o     = fifo_cnt;
    assign inflight_cnt_o = inflight_cnt;
    assign err_o          = err;

    always_ff @(posedge clk_i) begin
        if (push) begin
            key_mem[wr_ptr] <= cmd_key_i;
            val_mem[wr_ptr] <= cmd_value_i;
            op_mem[wr_ptr]  <= cmd_opcode_i;
        end
        if (pop) slot_key[out_tag_o] <= out_key_o;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            busy         <= '0;
            inflight_cnt <= '0;
            err          <= 1'b0;
            hold         <= 1'b0;
            hold_tag     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            hold     <= out_valid_o && !out_ready_i;
            hold_tag <= out_tag_o;

            // Issue only targets idle slots, so it never collides with a valid retire.
            if (retire_ok) busy[res_tag_i] <= 1'b0;
            if (pop)       busy[out_tag_o] <= 1'b1;
            case ({pop, retire_ok})
                2'b10:   inflight_cnt <= inflight_cnt + ICNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - ICNT_W'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase

            if ((accept && (cmd_opcode_i == OP_RSVD)) || (retire && !busy[res_tag_i]))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ht_cmd_ingress.sv
// Directed bench for ht_cmd_ingress with an in-order scoreboard and a slot
// occupancy model that predicts tags and in-flight counts.
module tb_ht_cmd_ingress;

    typedef struct packed {
        logic [31:0] key;
        logic [15:0] val;
        logic [1:0]  op;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i, cmd_ready_o;
    logic [31:0] cmd_key_i;
    logic [15:0] cmd_value_i;
    logic [1:0]  cmd_opcode_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_key_o;
    logic [15:0] out_value_o;
    logic [1:0]  out_opcode_o;
    logic [1:0]  out_tag_o;
    logic        res_valid_i, res_ready_i;
    logic [1:0]  res_tag_i;
    logic [3:0]  fifo_cnt_o;
    logic [2:0]  inflight_cnt_o;
    logic        err_o;

    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t sb[$];
    logic [3:0] tb_busy = '0;

    always #5 clk = ~clk;

    ht_cmd_ingress #(
        .KEY_WIDTH(32), .VALUE_WIDTH(16), .DEPTH(8), .MAX_INFLIGHT(4)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_key_i(cmd_key_i), .cmd_value_i(cmd_value_i), .cmd_opcode_i(cmd_opcode_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_key_o(out_key_o), .out_value_o(out_value_o),
        .out_opcode_o(out_opcode_o), .out_tag_o(out_tag_o),
        .res_valid_i(res_valid_i), .res_ready_i(res_ready_i), .res_tag_i(res_tag_i),
        .fifo_cnt_o(fifo_cnt_o), .inflight_cnt_o(inflight_cnt_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] k, input logic [15:0] v, input logic [1:0] op);
        logic acc;
        acc          = 1'b0;
        cmd_valid_i  = 1'b1;
        cmd_key_i    = k;
        cmd_value_i  = v;
        cmd_opcode_i = op;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = cmd_ready_o;
            cyc();
            if (acc) break;
        end
        cmd_valid_i = 1'b0;
        chk("send_accepted", acc, 1'b1);
    endtask

    task automatic retire(input logic [1:0] t);
        res_valid_i = 1'b1;
        res_ready_i = 1'b1;
        res_tag_i   = t;
        cyc();
        res_valid_i = 1'b0;
    endtask

    // Scoreboard and slot model, sampled mid-cycle for the edge that follows.
    always @(negedge clk) begin
        logic [3:0] nb;
        logic [1:0] exp_tag;
        cmd_t       e;
        if (!rst_n) begin
            sb.delete();
            tb_busy = '0;
        end else begin
            chk("inflight_model", inflight_cnt_o, $countones(tb_busy));
            nb = tb_busy;
            if (out_valid_o && out_ready_i) begin
                exp_tag = 2'd0;
                for (int i = 3; i >= 0; i--) if (!tb_busy[i]) exp_tag = 2'(i);
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL issue_unexpected: observed key %0h expected no issue", out_key_o);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("issue_key", out_key_o, e.key);
                    chk("issue_val", out_value_o, e.val);
                    chk("issue_op", out_opcode_o, e.op);
                    chk("issue_tag", out_tag_o, exp_tag);
                end
                nb[out_tag_o] = 1'b1;
            end
            if (res_valid_i && res_ready_i && tb_busy[res_tag_i]) nb[res_tag_i] = 1'b0;
            tb_busy = nb;
            if (cmd_valid_i && cmd_ready_o && cmd_opcode_i != 2'd3)
                sb.push_back('{key: cmd_key_i, val: cmd_value_i, op: cmd_opcode_i});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rt;
        rst_n        = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_key_i    = '0;
        cmd_value_i  = '0;
        cmd_opcode_i = '0;
        out_ready_i  = 1'b0;
        res_valid_i  = 1'b0;
        res_ready_i  = 1'b0;
        res_tag_i    = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_cmd_ready", cmd_ready_o, 1'b0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_fifo_cnt", fifo_cnt_o, 4'd0);
        chk("rst_inflight", inflight_cnt_o, 3'd0);
        chk("rst_err", err_o, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", cmd_ready_o, 1'b1);

        // 1: single INSERT issues the cycle after accept
        out_ready_i = 1'b1;
        send(32'h0100_0000, 16'h1234, 2'd1);
        chk("t1_out_valid", out_valid_o, 1'b1);
        chk("t1_tag", out_tag_o, 2'd0);
        chk("t1_fifo_cnt", fifo_cnt_o, 4'd1);
        cyc();
        chk("t1_inflight", inflight_cnt_o, 3'd1);
        chk("t1_fifo_empty", fifo_cnt_o, 4'd0);
        retire(2'd0);
        chk("t1_retired", inflight_cnt_o, 3'd0);

        // 2: same-key SEARCH waits for the INSERT to retire
        send(32'h0500_0000, 16'h0055, 2'd1);
        send(32'h0500_0000, 16'h0066, 2'd0);
        chk("t2_held", out_valid_o, 1'b0);
        chk("t2_inflight", inflight_cnt_o, 3'd1);
        chk("t2_fifo_cnt", fifo_cnt_o, 4'd1);
        cyc();
        chk("t2_still_held", out_valid_o, 1'b0);
        retire(2'd0);
        chk("t2_released", out_valid_o, 1'b1);
        chk("t2_tag", out_tag_o, 2'd0);
        cyc();
        chk("t2_inflight_after", inflight_cnt_o, 3'd1);
        retire(2'd0);

        // 3: fill the FIFO, reject a ninth, then drain in order
        out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++)
            send(32'h3000_0000 + 32'(i), 16'hA000 + 16'(i), 2'(i % 3));
        chk("t3_full_ready", cmd_ready_o, 1'b0);
        chk("t3_full_cnt", fifo_cnt_o, 4'd8);
        chk("t3_head_offer", out_valid_o, 1'b1);
        cmd_valid_i  = 1'b1;
        cmd_key_i    = 32'h3000_00FF;
        cmd_value_i  = 16'hBEEF;
        cmd_opcode_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_ninth_ready", cmd_ready_o, 1'b0);
            chk("t3_ninth_cnt", fifo_cnt_o, 4'd8);
        end
        cmd_valid_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 80 && (sb.size() != 0 || tb_busy != 0); i++) begin
            res_valid_i = 1'b0;
            rt = 2'd0;
            for (int j = 3; j >= 0; j--) if (tb_busy[j]) rt = 2'(j);
            if (tb_busy != 0) begin
                res_valid_i = 1'b1;
                res_ready_i = 1'b1;
                res_tag_i   = rt;
            end
            cyc();
        end
        res_valid_i = 1'b0;
        chk("t3_drained_fifo", fifo_cnt_o, 4'd0);
        chk("t3_drained_sb", sb.size(), 0);
        chk("t3_drained_inflight", inflight_cnt_o, 3'd0);

        // 4: four keys fill the tracker; fifth waits for tag 2
        for (int i = 0; i < 4; i++)
            send(32'h0400_0000 + 32'(i), 16'h4400 + 16'(i), 2'd1);
        send(32'h0400_0010, 16'h4410, 2'd2);
        chk("t4_inflight_full", inflight_cnt_o, 3'd4);
        chk("t4_stall", out_valid_o, 1'b0);
        cyc();
        chk("t4_still_stall", out_valid_o, 1'b0);
        retire(2'd2);
        chk("t4_resume", out_valid_o, 1'b1);
        chk("t4_tag", out_tag_o, 2'd2);
        chk("t4_inflight_3", inflight_cnt_o, 3'd3);
        cyc();
        chk("t4_inflight_4", inflight_cnt_o, 3'd4);
        for (int i = 0; i < 4; i++) retire(2'(i));
        chk("t4_all_retired", inflight_cnt_o, 3'd0);

        // 5: retire of idle slot and reserved opcode
        chk("t5_err_before", err_o, 1'b0);
        retire(2'd1);
        chk("t5_err_set", err_o, 1'b1);
        cyc();
        chk("t5_err_sticky", err_o, 1'b1);
        send(32'h0700_0000, 16'h7777, 2'd3);
        chk("t5_rsvd_dropped", fifo_cnt_o, 4'd0);
        chk("t5_rsvd_no_issue", out_valid_o, 1'b0);
        chk("t5_err_still", err_o, 1'b1);

        // 6: asynchronous reset with buffered and in-flight state
        for (int i = 0; i < 3; i++)
            send(32'h0600_0000 + 32'(i), 16'h6600 + 16'(i), 2'd1);
        cyc();
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            send(32'h0600_0010 + 32'(i), 16'h6610 + 16'(i), 2'd0);
        chk("t6_fifo5", fifo_cnt_o, 4'd5);
        chk("t6_inflight3", inflight_cnt_o, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_fifo", fifo_cnt_o, 4'd0);
        chk("t6_rst_inflight", inflight_cnt_o, 3'd0);
        chk("t6_rst_out_valid", out_valid_o, 1'b0);
        chk("t6_rst_ready", cmd_ready_o, 1'b0);
        chk("t6_rst_err", err_o, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_ready_after", cmd_ready_o, 1'b1);
        chk("t6_out_valid_after", out_valid_o, 1'b0);
        chk("t6_fifo_after", fifo_cnt_o, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
